// File: rtl/des_decrypt_core.sv
// des_decrypt_core: iterative DES decryption, one Feistel round per clock.
// Subkeys run K16..K1 by rotating C/D right; S-box modules live alongside.

module sbox_lut #(
    parameter logic [255:0] T = '0
) (
    input  logic [5:0] in,
    output logic [3:0] out
);
    logic [5:0] idx;
    assign idx = {in[5], in[0], in[4:1]};
    // entry 0 is the top nibble of T
    assign out = T[{~idx, 2'b00} +: 4];
endmodule

module S_Box_1 (input logic [5:0] in, output logic [3:0] out);
    sbox_lut #(.T(256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D))
        u_lut (.in(in), .out(out));
endmodule

module S_Box_2 (input logic [5:0] in, output logic [3:0] out);
    sbox_lut #(.T(256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9))
        u_lut (.in(in), .out(out));
endmodule

module S_Box_3 (input logic [5:0] in, output logic [3:0] out);
    sbox_lut #(.T(256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C))
        u_lut (.in(in), .out(out));
endmodule

module S_Box_4 (input logic [5:0] in, output logic [3:0] out);
    sbox_lut #(.T(256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E))
        u_lut (.in(in), .out(out));
endmodule

module S_Box_5 (input logic [5:0] in, output logic [3:0] out);
    sbox_lut #(.T(256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453))
        u_lut (.in(in), .out(out));
endmodule

module S_Box_6 (input logic [5:0] in, output logic [3:0] out);
    sbox_lut #(.T(256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D))
        u_lut (.in(in), .out(out));
endmodule

module S_Box_7 (input logic [5:0] in, output logic [3:0] out);
    sbox_lut #(.T(256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C))
        u_lut (.in(in), .out(out));
endmodule

module S_Box_8 (input logic [5:0] in, output logic [3:0] out);
    sbox_lut #(.T(256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B))
        u_lut (.in(in), .out(out));
endmodule

module des_decrypt_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [63:0] in_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam int IPT [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FPT [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
    localparam int ET [48] = '{
        32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23,
        24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
    localparam int PT [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    localparam int PC1T [56] = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
    localparam int PC2T [48] = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
        23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    function automatic logic [63:0] ip_f(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IPT[i]];
        return y;
    endfunction

    function automatic logic [63:0] fp_f(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FPT[i]];
        return y;
    endfunction

    function automatic logic [47:0] e_f(input logic [31:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[47-i] = x[32-ET[i]];
        return y;
    endfunction

    function automatic logic [31:0] p_f(input logic [31:0] x);
        logic [31:0] y;
        for (int i = 0; i < 32; i++) y[31-i] = x[32-PT[i]];
        return y;
    endfunction

    function automatic logic [55:0] pc1_f(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1T[i]];
        return y;
    endfunction

    function automatic logic [47:0] pc2_f(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2T[i]];
        return y;
    endfunction

    state_t      state, state_nxt;
    logic [31:0] l, r, f, r_nxt, sb_out;
    logic [27:0] c, d, c_rot, d_rot;
    logic [47:0] sb_in;
    logic [3:0]  round_cnt;
    logic        last, one;

    assign sb_in = e_f(r) ^ pc2_f({c, d});

    S_Box_1 u_s1 (.in(sb_in[47:42]), .out(sb_out[31:28]));
    S_Box_2 u_s2 (.in(sb_in[41:36]), .out(sb_out[27:24]));
    S_Box_3 u_s3 (.in(sb_in[35:30]), .out(sb_out[23:20]));
    S_Box_4 u_s4 (.in(sb_in[29:24]), .out(sb_out[19:16]));
    S_Box_5 u_s5 (.in(sb_in[23:18]), .out(sb_out[15:12]));
    S_Box_6 u_s6 (.in(sb_in[17:12]), .out(sb_out[11:8]));
    S_Box_7 u_s7 (.in(sb_in[11:6]),  .out(sb_out[7:4]));
    S_Box_8 u_s8 (.in(sb_in[5:0]),   .out(sb_out[3:0]));

    assign f     = p_f(sb_out);
    assign r_nxt = l ^ f;
    assign last  = round_cnt == 4'd15;
    // single-step rotation precedes rounds 2, 9 and 16
    assign one   = (round_cnt == 4'd0) || (round_cnt == 4'd7)
                || (round_cnt == 4'd14);
    assign c_rot = one ? {c[0], c[27:1]} : {c[1:0], c[27:2]};
    assign d_rot = one ? {d[0], d[27:1]} : {d[1:0], d[27:2]};

    assign in_ready = rst_n && (state == IDLE);
    assign busy     = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid)  state_nxt = ROUND;
            ROUND:   if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l         <= '0;
            r         <= '0;
            c         <= '0;
            d         <= '0;
            round_cnt <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    {l, r}    <= ip_f(in_data);
                    {c, d}    <= pc1_f(in_key);
                    round_cnt <= '0;
                end
                ROUND: begin
                    l         <= r;
                    r         <= r_nxt;
                    round_cnt <= round_cnt + 4'd1;
                    if (!last) begin
                        c <= c_rot;
                        d <= d_rot;
                    end else begin
                        out_data  <= fp_f({r_nxt, r});
                        out_valid <= 1'b1;
                    end
                end
                DONE: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_des_decrypt_core.sv
// Directed bench for des_decrypt_core: known DES vectors, handshakes,
// reset abort and a behavioural encryptor feeding back-to-back blocks.

module tb_des_decrypt_core;
    logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, busy;
    logic [63:0] in_data, in_key, out_data;
    int          checks = 0;
    int          errors = 0;

    des_decrypt_core dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_key(in_key), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] C1 = 64'h85E813540F0AB405;
    localparam logic [63:0] P1 = 64'h0123456789ABCDEF;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int E_T [48] = '{
        32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23,
        24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
    localparam int P_T [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
        23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int SB [8][64] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
          0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
          4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
          15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
        '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
          3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
          0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
          13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
        '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
          13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
          1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
        '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
          13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
          10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
          3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
        '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
          14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
          4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
          11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
          10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
          9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
          4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
        '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
          13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
          1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
          6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
        '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
          1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
          7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
          2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

    // forward cipher: left-rotating key schedule, FP built as IP inverse
    function automatic logic [63:0] des_enc(input logic [63:0] pt,
                                            input logic [63:0] key);
        logic [63:0] x, y;
        logic [55:0] cd;
        logic [47:0] e, k;
        logic [31:0] l, r, s, f;
        logic [27:0] c, d;
        logic [5:0]  six;
        int          idx;
        for (int i = 0; i < 64; i++) x[63-i] = pt[64-IP_T[i]];
        l = x[63:32];
        r = x[31:0];
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int rnd = 0; rnd < 16; rnd++) begin
            for (int n = 0; n < SH[rnd]; n++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) k[47-i] = cd[56-PC2_T[i]];
            for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
            e = e ^ k;
            for (int b = 0; b < 8; b++) begin
                six = e[47-6*b -: 6];
                idx = 32 * int'(six[5]) + 16 * int'(six[0]) + int'(six[4:1]);
                s[31-4*b -: 4] = 4'(SB[b][idx]);
            end
            for (int i = 0; i < 32; i++) f[31-i] = s[32-P_T[i]];
            {l, r} = {r, l ^ f};
        end
        x = {r, l};
        for (int i = 0; i < 64; i++) y[64-IP_T[i]] = x[63-i];
        return y;
    endfunction

    task automatic accept(input logic [63:0] ct, input logic [63:0] key,
                          output bit ok);
        logic rdy;
        in_data  = ct;
        in_key   = key;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 64 && !ok; n++) begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) ok = 1'b1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int n = 1; n <= 40 && !ok; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                ok  = 1'b1;
                lat = n;
            end
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl got rdy=%b vld=%b busy=%b want 0 0 0",
                     in_ready, out_valid, busy);
        end
        checks++;
        if (out_data !== 64'h0) begin
            errors++;
            $display("FAIL reset_data got %h want 0", out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got rdy=%b busy=%b want 1 0",
                     in_ready, busy);
        end
    endtask

    task automatic test_vector1();
        bit ok, vok;
        int lat;
        accept(C1, K1, ok);
        checks++;
        if (!ok || busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL v1_accept got ok=%b busy=%b rdy=%b want 1 1 0",
                     ok, busy, in_ready);
        end
        wait_out(lat, vok);
        checks++;
        if (!vok || lat != 16) begin
            errors++;
            $display("FAIL v1_latency got %0d want 16", lat);
        end
        checks++;
        if (out_data !== P1) begin
            errors++;
            $display("FAIL v1_data got %h want %h", out_data, P1);
        end
        handshake();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL v1_release got vld=%b rdy=%b busy=%b want 0 1 0",
                     out_valid, in_ready, busy);
        end
    endtask

    task automatic test_parity();
        logic [63:0] keys [3] = '{64'h0, 64'h0101010101010101,
                                  64'h123556789ABDDEF0};
        logic [63:0] cts  [3] = '{64'h8CA64DE9C1B123A7,
                                  64'h8CA64DE9C1B123A7, C1};
        logic [63:0] exps [3] = '{64'h0, 64'h0, P1};
        bit ok, vok;
        int lat;
        for (int i = 0; i < 3; i++) begin
            accept(cts[i], keys[i], ok);
            wait_out(lat, vok);
            checks++;
            if (!ok || !vok || out_data !== exps[i]) begin
                errors++;
                $display("FAIL parity_%0d got %h want %h", i, out_data, exps[i]);
            end
            handshake();
        end
    endtask

    task automatic test_hold();
        logic [63:0] exp = 64'h8787878787878787;
        bit ok, vok;
        int lat;
        accept(64'h0, 64'h0E329232EA6D0D73, ok);
        wait_out(lat, vok);
        checks++;
        if (!ok || !vok || out_data !== exp) begin
            errors++;
            $display("FAIL hold_data got %h want %h", out_data, exp);
        end
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d got vld=%b rdy=%b %h want 1 0 %h",
                         n, out_valid, in_ready, out_data, exp);
            end
        end
        handshake();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== exp) begin
            errors++;
            $display("FAIL hold_release got vld=%b rdy=%b %h want 0 1 %h",
                     out_valid, in_ready, out_data, exp);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_idle got busy=%b vld=%b want 0 0",
                     busy, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        bit ok, vok, seen;
        int lat;
        accept(C1, K1, ok);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 ||
            out_data !== 64'h0) begin
            errors++;
            $display("FAIL midrst got vld=%b busy=%b rdy=%b %h want 0 0 0 0",
                     out_valid, busy, in_ready, out_data);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL midrst_quiet got activity=1 want 0");
        end
        accept(C1, K1, ok);
        wait_out(lat, vok);
        checks++;
        if (!ok || !vok || lat != 16 || out_data !== P1) begin
            errors++;
            $display("FAIL midrst_again got lat=%0d %h want 16 %h",
                     lat, out_data, P1);
        end
        handshake();
    endtask

    task automatic test_ignore_busy();
        logic [63:0] cap = '0;
        int seen_out = -1;
        int acc2 = -1;
        bit ok, vok;
        int lat;
        accept(C1, K1, ok);
        in_data  = 64'h8CA64DE9C1B123A7;
        in_key   = 64'h0;
        in_valid = 1'b1;
        for (int n = 1; n <= 40 && acc2 < 0; n++) begin
            @(posedge clk);
            #1;
            if (out_ready) out_ready = 1'b0;
            else if (seen_out < 0 && out_valid) begin
                seen_out  = n;
                cap       = out_data;
                out_ready = 1'b1;
            end else if (seen_out >= 0 && busy) acc2 = n;
        end
        in_valid = 1'b0;
        checks++;
        if (!ok || seen_out != 16 || cap !== P1) begin
            errors++;
            $display("FAIL busy_first got lat=%0d %h want 16 %h",
                     seen_out, cap, P1);
        end
        checks++;
        if (acc2 != 18) begin
            errors++;
            $display("FAIL busy_spacing got %0d want 18", acc2);
        end
        wait_out(lat, vok);
        checks++;
        if (!vok || lat != 16 || out_data !== 64'h0) begin
            errors++;
            $display("FAIL busy_second got lat=%0d %h want 16 0", lat, out_data);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        logic [63:0] pts  [4] = '{64'h0011223344556677, 64'hFEDCBA9876543210,
                                  64'h4E6F772069732074, 64'hDEADBEEFCAFEF00D};
        logic [63:0] keys [4] = '{64'h0123456789ABCDEF, 64'hA5A5A5A55A5A5A5A,
                                  64'h0123456789ABCDEF, 64'h1F1F1F1F0E0E0E0E};
        logic rdy;
        int i = 0;
        int j = 0;
        out_ready = 1'b1;
        in_data   = des_enc(pts[0], keys[0]);
        in_key    = keys[0];
        in_valid  = 1'b1;
        for (int n = 0; n < 200 && j < 4; n++) begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy && in_valid) begin
                i++;
                if (i < 4) begin
                    in_data = des_enc(pts[i], keys[i]);
                    in_key  = keys[i];
                end else in_valid = 1'b0;
            end
            if (out_valid) begin
                checks++;
                if (out_data !== pts[j]) begin
                    errors++;
                    $display("FAIL b2b_%0d got %h want %h", j, out_data, pts[j]);
                end
                j++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (j != 4) begin
            errors++;
            $display("FAIL b2b_count got %0d want 4", j);
        end
    endtask

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        in_key    = '0;
        test_reset();
        test_vector1();
        test_parity();
        test_hold();
        test_reset_mid();
        test_ignore_busy();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/des_decrypt_core.md
Name: des_decrypt_core

Overview:
Iterative single-block DES decryption engine: the inverse direction of the team's DES encryption datapath. It takes a 64-bit ciphertext and a 64-bit key through a valid/ready handshake and runs 16 Feistel rounds, one per clock, with subkeys applied in reverse order (K16..K1). It returns the 64-bit plaintext through a valid/ready output handshake. The f-function instantiates the existing S_Box_1..S_Box_8 modules (6-bit in, 4-bit out, row = {in[5],in[0]}, column = in[4:1]); S-box tables are not duplicated.

Parameters:
None. The DES permutation tables, the round count (16) and the shift schedule are fixed constants.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  ciphertext/key present
in_ready  output  1  core can accept a block
in_data  input  64  ciphertext, bit 63 = DES bit 1
in_key  input  64  DES key incl. parity bits (bits 56,48,...,0 ignored)
out_valid  output  1  plaintext present
out_ready  input  1  downstream accepts plaintext
out_data  output  64  plaintext, bit 63 = DES bit 1
busy  output  1  high in ROUND or DONE

Behaviour:
- Reset (async, rst_n low): state=IDLE, round_cnt=0, L/R/C/D=0, out_data=0, out_valid=0, busy=0. in_ready = rst_n && (state==IDLE), so it is 0 while reset is asserted.
- States:
  - IDLE: in_ready=1. If in_valid is high at a rising edge, the block is accepted: L||R <= IP(in_data); C||D <= PC1(in_key); round_cnt<=0; go to ROUND.
  - ROUND: one round per edge.
    - Subkey = PC2(C,D) taken from the current C/D.
    - Round step: L<=R; R<=L ^ f(R,subkey).
    - f = P(Sbox(E(R) ^ subkey)), with S_Box_1 fed bits 47:42 and S_Box_8 fed bits 5:0.
    - After the round, C and D each rotate right by the amount for the next round: 1 after rounds 1, 8 and 15; 2 after the others; none after round 16. The full decrypt schedule is 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. The first round therefore uses PC2(PC1 key) unshifted, which is K16.
    - round_cnt increments. On the edge where round_cnt==15: out_data <= FP(R_new||L_new) (swap of the final halves), out_valid<=1, go to DONE.
  - DONE: out_valid and out_data are held stable until out_ready is high at an edge. Then out_valid<=0 and state returns to IDLE. out_data keeps its last value.
- Latency: out_valid rises on the 16th rising edge after the accepting edge. Minimum spacing between accepts is 18 cycles.
- in_ready is 0 in ROUND and DONE. in_valid and in_data are ignored there and no buffering is done. An upstream block held valid is accepted on the first IDLE edge.
- in_data and in_key are sampled only on the accept edge. Changes afterwards have no effect.
- out_ready in IDLE or ROUND has no effect.
- Key parity bits never affect the result.
- Reset mid-operation: the block is aborted, nothing is output, and IDLE is entered immediately.
- Datapath is fully registered (L,R 32b; C,D 28b). Round logic is combinational between registers.

Test Plan:
1. key 133457799BBCDFF1, ct 85E813540F0AB405 -> out_data 0123456789ABCDEF, out_valid high exactly 16 edges after accept.
2. key 0000000000000000, ct 8CA64DE9C1B123A7 -> 0000000000000000. Repeat with key 0101010101010101 (parity only) -> identical result.
3. key 0E329232EA6D0D73, ct 0000000000000000 -> 8787878787878787. Hold out_ready=0 for 10 cycles: out_valid and out_data stay stable, in_ready stays 0. Release it: one handshake, then IDLE.
4. Keep in_valid high with new data/key during ROUND -> nothing is sampled. The second block is accepted on the edge after the output handshake. Both results are correct, 18-cycle spacing.
5. Assert rst_n low at round 7 -> all outputs go to reset values immediately and no out_valid is produced. A block accepted after release returns the correct plaintext (vector 1).
6. Back-to-back: 4 random blocks encrypted by the team's encryption model -> all decrypt to the originals in order.
